simon_param_core: RTL and testbench
===================================

# simon_param_core

Parametrised, iterative Simon block cipher engine covering every standard Simon (word size, key words) pair, with runtime encrypt/decrypt selection. A key-expansion phase fills an on-chip round-key store. Encryption or decryption then runs one round per clock. It is the successor to the fixed 64/128 encrypt-only `simon` core and sits behind the same style of `en`/`done` control used by the crypto testbenches.

## Interface
- `N`, default 32: word size in bits; block is 2N bits.
- `M`, default 4: number of key words; key is N*M bits.
- Legal (N,M) pairs, with round count T and z-sequence:
  - 16/4: T=32, z0
  - 24/3: T=36, z0
  - 24/4: T=36, z1
  - 32/3: T=42, z2
  - 32/4: T=44, z3
  - 48/2: T=52, z2
  - 48/3: T=54, z3
  - 64/2: T=68, z2
  - 64/3: T=69, z3
  - 64/4: T=72, z4
- Any other pair is an elaboration error.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `key_load` in 1: sample `key` and start key expansion.
- `key` in N*M: key words; k0 = bits [N-1:0], k(M-1) = MS word.
- `key_ready` out 1: round-key store valid.
- `en` in 1: start one block operation.
- `mode` in 1: 0 = encrypt, 1 = decrypt; sampled with `en`.
- `text_in` in 2N: x = upper N bits, y = lower N bits.
- `text_out` out 2N: result, same packing as `text_in`.
- `busy` out 1: expansion or rounds in progress.
- `done` out 1: `text_out` valid.

## Operation
- States: IDLE, EXPAND, RUN, DONE.
- Round function: f(x) = (x<<<1 & x<<<8) ^ (x<<<2). All rotations are modulo N.
- Encrypt round i = 0..T-1: (x,y) <= (y ^ f(x) ^ k[i], x).
- Decrypt round j = 0..T-1 uses k[T-1-j]: (x,y) <= (y, x ^ f(y) ^ k[T-1-j]).
- Key schedule, for i = M..T-1:
  - t = k[i-1]>>>3.
  - If M=4, t ^= k[i-3].
  - t ^= t>>>1.
  - k[i] = ~k[i-M] ^ t ^ z[(i-M) mod 62] ^ 3.
  - z index is a 6-bit counter that wraps 61 to 0.
- Round-key store is T×N registers; it is not reset.
- key_load (any state): write k0..k(M-1), clear `key_ready` and `done`, go to EXPAND. One key word is computed per cycle until k[T-1] is written, then go to IDLE with `key_ready`=1.
- en when `key_ready`=1 and state is IDLE or DONE: latch `text_in` and `mode`, clear `done`, go to RUN, run T rounds, then go to DONE.
- DONE: `done`=1 and `text_out` held until the next accepted `en`, `key_load`, or reset.
- en ignored when `key_ready`=0 or state is EXPAND or RUN; no queueing.
- key_load and en asserted in the same cycle: key_load wins and en is dropped.
- key_load during RUN aborts the operation: `done` stays 0 and `text_out` keeps its old value.
- The key is retained across operations; back-to-back blocks need no reload.

## Timing
- Reset values: `text_out`=0, `done`=0, `key_ready`=0, `busy`=0, state IDLE, counters 0. Reset mid-operation returns to this state, and the key must be reloaded.
- Key expansion: key_load sampled at edge L; `key_ready` rises after edge L+(T-M), giving 40 cycles for 32/4. `busy`=1 from edge L until that edge.
- Block latency: en sampled at edge E; round r completes at edge E+r; `done` and `text_out` valid after edge E+T, giving 44 cycles for 32/4. `busy`=1 from edge E to edge E+T.
- Minimum issue interval is T+1 cycles: en may be accepted in the first DONE cycle.
- `text_out` updates only on the DONE transition; intermediate round state is never visible.

## Test plan
- N=32,M=4, key 1b1a19181312111 00b0a090803020100 (i.e. 128'h1b1a1918131211100b0a090803020100), encrypt 656b696c20646e75:
  - `text_out` = 44c8fc20b9dfa07a.
  - `key_ready` exactly 40 cycles after key_load; `done` exactly 44 cycles after en.
- Same key, decrypt 44c8fc20b9dfa07a -> 656b696c20646e75.
- Chain of 3 encrypts feeding `text_out` back as `text_in` with no key reload: decrypting the chain in reverse recovers the original plaintext.
- N=16,M=4, key 1918111009080100:
  - Encrypt 65656877 -> c69be9bb; decrypt back -> 65656877.
- N=64,M=2, key 0f0e0d0c0b0a09080706050403020100:
  - Encrypt 63736564207372656c6c657661727420 -> 49681b1e1e54fe3f65aa832af84e0bbc, with T=68.
- Control corner cases:
  - en pulsed during RUN, and en before `key_ready`: both ignored.
  - key_load + en in the same cycle: expansion only.
  - key_load at round 10: `done` never rises, `key_ready` drops then returns.
  - `rst` low at round 20: all outputs return to 0 immediately (asynchronously).

Source files
------------

// File: rtl/simon_param_core.sv
// Iterative Simon block cipher for every standard (N,M) pair: one key word per
// cycle during expansion into a round-key store, then one round per clock.
module simon_param_core #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [N*M-1:0]   key,
  output logic             key_ready,
  input  logic             en,
  input  logic             mode,
  input  logic [2*N-1:0]   text_in,
  output logic [2*N-1:0]   text_out,
  output logic             busy,
  output logic             done
);

  function automatic int unsigned calc_rounds(input int unsigned n, input int unsigned m);
    if (n == 16 && m == 4) return 32;
    if (n == 24 && m == 3) return 36;
    if (n == 24 && m == 4) return 36;
    if (n == 32 && m == 3) return 42;
    if (n == 32 && m == 4) return 44;
    if (n == 48 && m == 2) return 52;
    if (n == 48 && m == 3) return 54;
    if (n == 64 && m == 2) return 68;
    if (n == 64 && m == 3) return 69;
    if (n == 64 && m == 4) return 72;
    return 0;
  endfunction

  // z sequences written leftmost-first; element j of the sequence is bit 61-j
  function automatic logic [61:0] calc_z(input int unsigned n, input int unsigned m);
    if ((n == 16 && m == 4) || (n == 24 && m == 3))
      return 62'b11111010001001010110000111001101111101000100101011000011100110;
    if (n == 24 && m == 4)
      return 62'b10001110111110010011000010110101000111011111001001100001011010;
    if ((n == 32 && m == 3) || (n == 48 && m == 2) || (n == 64 && m == 2))
      return 62'b10101111011100000011010010011000101000010001111110010110110011;
    if ((n == 32 && m == 4) || (n == 48 && m == 3) || (n == 64 && m == 3))
      return 62'b11011011101011000110010111100000010010001010011100110100001111;
    return 62'b11010001111001101011011000100000010111000011001010010011101111;
  endfunction

  localparam int unsigned T  = calc_rounds(N, M);
  localparam int unsigned AW = $clog2(T);
  localparam logic [61:0]  Z  = calc_z(N, M);
  localparam logic [N-1:0] C3 = N'(3);

  if (T == 0) begin : g_bad_params
    $error("simon_param_core: unsupported (N,M) pair");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_RUN, S_DONE} state_t;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] f_round(input logic [N-1:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] kcnt_q, kcnt_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic [5:0]    zcnt_q, zcnt_d;
  logic [N-1:0]  x_q, x_d, y_q, y_d;
  logic          mode_q, mode_d;
  logic [2*N-1:0] text_d;
  logic          done_d, key_ready_d, busy_d;
  logic          load_c, exp_we_c;

  logic [N-1:0]  rk_mem [T];
  logic [N-1:0]  newk_c, t1_c, t2_c, t3_c;
  logic [N-1:0]  rk_c, nx_c, ny_c;
  logic [AW-1:0] ridx_c;
  logic          zbit_c;

  // Next key word from the three (or two) previous words in the store
  always_comb begin
    zbit_c = Z[6'd61 - zcnt_q];
    t1_c   = rotr(rk_mem[kcnt_q - AW'(1)], 3);
    t2_c   = t1_c;
    if (M == 4) t2_c = t1_c ^ rk_mem[kcnt_q - AW'(3)];
    t3_c   = t2_c ^ rotr(t2_c, 1);
    newk_c = ~rk_mem[kcnt_q - AW'(M)] ^ t3_c ^ N'(zbit_c) ^ C3;
  end

  // One encrypt or decrypt round; decryption walks the store backwards
  always_comb begin
    ridx_c = mode_q ? (AW'(T - 1) - rcnt_q) : rcnt_q;
    rk_c   = rk_mem[ridx_c];
    if (mode_q) begin
      nx_c = y_q;
      ny_c = x_q ^ f_round(y_q) ^ rk_c;
    end else begin
      nx_c = y_q ^ f_round(x_q) ^ rk_c;
      ny_c = x_q;
    end
  end

  // Round-key store: no reset, contents are only meaningful once key_ready is set
  always_ff @(posedge clk) begin
    if (load_c) begin
      for (int j = 0; j < int'(M); j++) rk_mem[AW'(j)] <= key[j*N +: N];
    end else if (exp_we_c) begin
      rk_mem[kcnt_q] <= newk_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      kcnt_q    <= '0;
      rcnt_q    <= '0;
      zcnt_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= 1'b0;
      text_out  <= '0;
      done      <= 1'b0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      kcnt_q    <= kcnt_d;
      rcnt_q    <= rcnt_d;
      zcnt_q    <= zcnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      mode_q    <= mode_d;
      text_out  <= text_d;
      done      <= done_d;
      key_ready <= key_ready_d;
      busy      <= busy_d;
    end
  end

  // key_load has priority over everything, including a same-cycle en
  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    rcnt_d      = rcnt_q;
    zcnt_d      = zcnt_q;
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    text_d      = text_out;
    done_d      = done;
    key_ready_d = key_ready;
    load_c      = 1'b0;
    exp_we_c    = 1'b0;

    if (key_load) begin
      load_c      = 1'b1;
      key_ready_d = 1'b0;
      done_d      = 1'b0;
      kcnt_d      = AW'(M);
      zcnt_d      = '0;
      rcnt_d      = '0;
      state_d     = S_EXPAND;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (en && key_ready) begin
            x_d     = text_in[2*N-1:N];
            y_d     = text_in[N-1:0];
            mode_d  = mode;
            rcnt_d  = '0;
            done_d  = 1'b0;
            state_d = S_RUN;
          end
        end
        S_EXPAND: begin
          exp_we_c = 1'b1;
          kcnt_d   = kcnt_q + AW'(1);
          zcnt_d   = (zcnt_q == 6'd61) ? 6'd0 : zcnt_q + 6'd1;
          if (kcnt_q == AW'(T - 1)) begin
            kcnt_d      = '0;
            key_ready_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_RUN: begin
          x_d    = nx_c;
          y_d    = ny_c;
          rcnt_d = rcnt_q + AW'(1);
          if (rcnt_q == AW'(T - 1)) begin
            rcnt_d  = '0;
            text_d  = {nx_c, ny_c};
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_EXPAND) || (state_d == S_RUN);
  end

endmodule

// File: tb/tb_simon_param_core.sv
// Bench for simon_param_core: three configurations (32/4, 16/4, 64/2) checked
// against known vectors and a behavioural Simon model.
module tb_simon_param_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   kl, en;
  logic         mode;
  logic [127:0] key_bus, txt_bus;
  logic [2:0]   kr, bz, dn;
  logic [63:0]  to32;
  logic [31:0]  to16;
  logic [127:0] to64;

  int checks = 0;
  int passes = 0;
  int n_of[3] = '{32, 16, 64};
  int m_of[3] = '{4, 4, 2};
  int t_of[3] = '{44, 32, 68};

  always #5 clk = ~clk;

  simon_param_core #(.N(32), .M(4)) u32 (
    .clk(clk), .rst(rst), .key_load(kl[0]), .key(key_bus), .key_ready(kr[0]),
    .en(en[0]), .mode(mode), .text_in(txt_bus[63:0]), .text_out(to32),
    .busy(bz[0]), .done(dn[0]));

  simon_param_core #(.N(16), .M(4)) u16 (
    .clk(clk), .rst(rst), .key_load(kl[1]), .key(key_bus[63:0]), .key_ready(kr[1]),
    .en(en[1]), .mode(mode), .text_in(txt_bus[31:0]), .text_out(to16),
    .busy(bz[1]), .done(dn[1]));

  simon_param_core #(.N(64), .M(2)) u64 (
    .clk(clk), .rst(rst), .key_load(kl[2]), .key(key_bus), .key_ready(kr[2]),
    .en(en[2]), .mode(mode), .text_in(txt_bus), .text_out(to64),
    .busy(bz[2]), .done(dn[2]));

  function automatic logic [63:0] rol(logic [63:0] v, int s, int n);
    logic [63:0] mask;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    v = v & mask;
    return ((v << s) | (v >> (n - s))) & mask;
  endfunction

  function automatic logic [63:0] fr(logic [63:0] v, int n);
    return (rol(v, 1, n) & rol(v, 8, n)) ^ rol(v, 2, n);
  endfunction

  // Reference Simon: full key schedule then T rounds, straight from the cipher definition
  function automatic logic [127:0] ref_model(int n, int m, logic [127:0] k_in, bit dec, logic [127:0] txt);
    string zs[5] = '{
      "11111010001001010110000111001101111101000100101011000011100110",
      "10001110111110010011000010110101000111011111001001100001011010",
      "10101111011100000011010010011000101000010001111110010110110011",
      "11011011101011000110010111100000010010001010011100110100001111",
      "11010001111001101011011000100000010111000011001010010011101111"};
    string zr;
    logic [63:0] k[72];
    logic [63:0] mask, t, x, y, tmp;
    int rounds, zi;
    rounds = 0; zi = 0;
    if (n == 16 && m == 4) begin rounds = 32; zi = 0; end
    if (n == 32 && m == 4) begin rounds = 44; zi = 3; end
    if (n == 64 && m == 2) begin rounds = 68; zi = 2; end
    zr = zs[zi];
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < m; i++) k[i] = 64'(k_in >> (i * n)) & mask;
    for (int i = m; i < rounds; i++) begin
      t = rol(k[i-1], n - 3, n);
      if (m == 4) t = t ^ k[i-3];
      t = t ^ rol(t, n - 1, n);
      k[i] = (~k[i-m] ^ t ^ 64'(zr.getc((i - m) % 62) == 8'h31) ^ 64'd3) & mask;
    end
    x = 64'(txt >> n) & mask;
    y = 64'(txt) & mask;
    for (int i = 0; i < rounds; i++) begin
      if (!dec) begin
        tmp = x; x = y ^ fr(x, n) ^ k[i]; y = tmp;
      end else begin
        tmp = y; y = x ^ fr(y, n) ^ k[rounds-1-i]; x = tmp;
      end
    end
    return (128'(x) << n) | 128'(y);
  endfunction

  function automatic logic [127:0] get_out(int sel);
    case (sel)
      0: return 128'(to32);
      1: return 128'(to16);
      default: return to64;
    endcase
  endfunction

  task automatic do_load(input int sel, input logic [127:0] k, output int cyc);
    @(negedge clk); key_bus = k; kl[sel] = 1'b1;
    @(posedge clk); #1; kl[sel] = 1'b0;
    cyc = 0;
    while (kr[sel] !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic do_block(input int sel, input bit md, input logic [127:0] txt,
                          output logic [127:0] res, output int cyc);
    @(negedge clk); txt_bus = txt; mode = md; en[sel] = 1'b1;
    @(posedge clk); #1; en[sel] = 1'b0;
    cyc = 0;
    while (dn[sel] !== 1'b1 && cyc < 300) begin @(posedge clk); #1; cyc++; end
    res = get_out(sel);
  endtask

  task automatic test_reset;
    rst = 1'b0; kl = '0; en = '0; mode = 1'b0; key_bus = '0; txt_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (kr !== 3'b000) $display("FAIL reset_key_ready got %b want 000", kr); else passes++;
    checks++; if (bz !== 3'b000) $display("FAIL reset_busy got %b want 000", bz); else passes++;
    checks++; if (dn !== 3'b000) $display("FAIL reset_done got %b want 000", dn); else passes++;
    checks++; if ({to32, to16, to64} !== '0) $display("FAIL reset_text_out got %h want 0", {to32, to16, to64}); else passes++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_kat32;
    logic [127:0] res; int cyc;
    do_load(0, 128'h1b1a1918131211100b0a090803020100, cyc);
    checks++; if (cyc !== 40) $display("FAIL kat32_expand_latency got %0d want 40", cyc); else passes++;
    checks++; if (bz[0] !== 1'b0) $display("FAIL kat32_busy_after_expand got %b want 0", bz[0]); else passes++;
    do_block(0, 1'b0, 128'h656b696c20646e75, res, cyc);
    checks++; if (res !== 128'h44c8fc20b9dfa07a) $display("FAIL kat32_encrypt got %h want 44c8fc20b9dfa07a", res); else passes++;
    checks++; if (cyc !== 44) $display("FAIL kat32_block_latency got %0d want 44", cyc); else passes++;
    checks++; if (bz[0] !== 1'b0) $display("FAIL kat32_busy_after_done got %b want 0", bz[0]); else passes++;
    do_block(0, 1'b1, 128'h44c8fc20b9dfa07a, res, cyc);
    checks++; if (res !== 128'h656b696c20646e75) $display("FAIL kat32_decrypt got %h want 656b696c20646e75", res); else passes++;
  endtask

  task automatic test_kat16;
    logic [127:0] res; int cyc;
    do_load(1, 128'h1918111009080100, cyc);
    checks++; if (cyc !== 28) $display("FAIL kat16_expand_latency got %0d want 28", cyc); else passes++;
    do_block(1, 1'b0, 128'h65656877, res, cyc);
    checks++; if (res !== 128'hc69be9bb) $display("FAIL kat16_encrypt got %h want c69be9bb", res); else passes++;
    checks++; if (cyc !== 32) $display("FAIL kat16_block_latency got %0d want 32", cyc); else passes++;
    do_block(1, 1'b1, 128'hc69be9bb, res, cyc);
    checks++; if (res !== 128'h65656877) $display("FAIL kat16_decrypt got %h want 65656877", res); else passes++;
  endtask

  task automatic test_kat64;
    logic [127:0] res; int cyc;
    do_load(2, 128'h0f0e0d0c0b0a09080706050403020100, cyc);
    checks++; if (cyc !== 66) $display("FAIL kat64_expand_latency got %0d want 66", cyc); else passes++;
    do_block(2, 1'b0, 128'h63736564207372656c6c657661727420, res, cyc);
    checks++; if (res !== 128'h49681b1e1e54fe3f65aa832af84e0bbc) $display("FAIL kat64_encrypt got %h want 49681b1e1e54fe3f65aa832af84e0bbc", res); else passes++;
    checks++; if (cyc !== 68) $display("FAIL kat64_block_latency got %0d want 68", cyc); else passes++;
  endtask

  task automatic test_random;
    logic [127:0] k, txt, res, exp; int cyc; bit md;
    for (int s = 0; s < 3; s++) begin
      for (int kk = 0; kk < 2; kk++) begin
        k = {$urandom, $urandom, $urandom, $urandom};
        do_load(s, k, cyc);
        checks++; if (cyc !== t_of[s] - m_of[s]) $display("FAIL rand_expand_latency cfg%0d got %0d want %0d", s, cyc, t_of[s] - m_of[s]); else passes++;
        for (int b = 0; b < 3; b++) begin
          txt = {$urandom, $urandom, $urandom, $urandom};
          md  = 1'($urandom_range(0, 1));
          exp = ref_model(n_of[s], m_of[s], k, md, txt);
          do_block(s, md, txt, res, cyc);
          checks++; if (res !== exp) $display("FAIL rand_block cfg%0d mode%0d got %h want %h", s, md, res, exp); else passes++;
          checks++; if (cyc !== t_of[s]) $display("FAIL rand_latency cfg%0d got %0d want %0d", s, cyc, t_of[s]); else passes++;
        end
      end
    end
  endtask

  task automatic test_chain;
    logic [127:0] k, pt, res, exp; logic [127:0] chain[$]; int cyc;
    k  = {$urandom, $urandom, $urandom, $urandom};
    pt = {64'd0, $urandom, $urandom};
    do_load(0, k, cyc);
    chain.push_back(pt);
    for (int i = 0; i < 3; i++) begin
      exp = ref_model(32, 4, k, 1'b0, chain[i]);
      do_block(0, 1'b0, chain[i], res, cyc);
      checks++; if (res !== exp) $display("FAIL chain_encrypt%0d got %h want %h", i, res, exp); else passes++;
      chain.push_back(res);
    end
    for (int i = 3; i > 0; i--) begin
      do_block(0, 1'b1, chain[i], res, cyc);
      checks++; if (res !== chain[i-1]) $display("FAIL chain_decrypt%0d got %h want %h", i, res, chain[i-1]); else passes++;
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] k, a, b, ra, rb; int cyc;
    k = 128'h1b1a1918131211100b0a090803020100;
    a = {64'd0, $urandom, $urandom};
    b = {64'd0, $urandom, $urandom};
    do_load(0, k, cyc);
    do_block(0, 1'b0, a, ra, cyc);
    // en in the first DONE cycle
    @(negedge clk); txt_bus = b; mode = 1'b0; en[0] = 1'b1;
    @(posedge clk); #1; en[0] = 1'b0;
    checks++; if ({dn[0], bz[0]} !== 2'b01) $display("FAIL b2b_accept got done/busy %b want 01", {dn[0], bz[0]}); else passes++;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (128'(to32) !== ra) $display("FAIL b2b_text_held got %h want %h", to32, ra); else passes++;
    cyc = 20;
    while (dn[0] !== 1'b1 && cyc < 300) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc !== 44) $display("FAIL b2b_latency got %0d want 44", cyc); else passes++;
    rb = ref_model(32, 4, k, 1'b0, b);
    checks++; if (128'(to32) !== rb) $display("FAIL b2b_result got %h want %h", to32, rb); else passes++;
  endtask

  task automatic test_ignored_en;
    logic [127:0] k, a, res, exp; int cyc;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); txt_bus = 128'h1234; mode = 1'b0; en[0] = 1'b1;
    @(negedge clk); en[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checks++; if ({dn[0], bz[0]} !== 2'b00) $display("FAIL en_no_key got done/busy %b want 00", {dn[0], bz[0]}); else passes++;
    k = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); key_bus = k; kl[0] = 1'b1;
    @(posedge clk); #1; kl[0] = 1'b0;
    cyc = 0;
    while (kr[0] !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      en[0] = (cyc == 5);
    end
    en[0] = 1'b0;
    checks++; if (cyc !== 40) $display("FAIL en_in_expand_latency got %0d want 40", cyc); else passes++;
    repeat (60) @(posedge clk);
    #1;
    checks++; if ({dn[0], bz[0]} !== 2'b00) $display("FAIL en_in_expand got done/busy %b want 00", {dn[0], bz[0]}); else passes++;
    a = {64'd0, $urandom, $urandom};
    exp = ref_model(32, 4, k, 1'b0, a);
    @(negedge clk); txt_bus = a; mode = 1'b0; en[0] = 1'b1;
    @(posedge clk); #1; en[0] = 1'b0;
    cyc = 0;
    while (dn[0] !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 5) begin txt_bus = ~a; mode = 1'b1; en[0] = 1'b1; end
      else en[0] = 1'b0;
    end
    res = 128'(to32);
    checks++; if (cyc !== 44) $display("FAIL en_in_run_latency got %0d want 44", cyc); else passes++;
    checks++; if (res !== exp) $display("FAIL en_in_run_result got %h want %h", res, exp); else passes++;
  endtask

  task automatic test_load_en_same;
    int cyc; bit saw_done;
    @(negedge clk);
    key_bus = 128'h1b1a1918131211100b0a090803020100; txt_bus = 128'h656b696c20646e75;
    mode = 1'b0; kl[0] = 1'b1; en[0] = 1'b1;
    @(posedge clk); #1; kl[0] = 1'b0; en[0] = 1'b0;
    checks++; if ({kr[0], bz[0], dn[0]} !== 3'b010) $display("FAIL same_cycle_state got kr/busy/done %b want 010", {kr[0], bz[0], dn[0]}); else passes++;
    cyc = 0; saw_done = 1'b0;
    while (kr[0] !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; if (dn[0]) saw_done = 1'b1; end
    repeat (50) begin @(posedge clk); #1; if (dn[0]) saw_done = 1'b1; end
    checks++; if (cyc !== 40) $display("FAIL same_cycle_expand got %0d want 40", cyc); else passes++;
    checks++; if (saw_done !== 1'b0) $display("FAIL same_cycle_done got %b want 0", saw_done); else passes++;
  endtask

  task automatic test_abort;
    logic [127:0] prev; int cyc; bit saw_done;
    do_block(0, 1'b0, 128'h656b696c20646e75, prev, cyc);
    @(negedge clk); txt_bus = 128'h0badcafe; mode = 1'b0; en[0] = 1'b1;
    @(posedge clk); #1; en[0] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); kl[0] = 1'b1;
    @(posedge clk); #1; kl[0] = 1'b0;
    checks++; if ({kr[0], dn[0]} !== 2'b00) $display("FAIL abort_flags got kr/done %b want 00", {kr[0], dn[0]}); else passes++;
    cyc = 0; saw_done = 1'b0;
    while (kr[0] !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; if (dn[0]) saw_done = 1'b1; end
    repeat (50) begin @(posedge clk); #1; if (dn[0]) saw_done = 1'b1; end
    checks++; if (cyc !== 40) $display("FAIL abort_rekey got %0d want 40", cyc); else passes++;
    checks++; if (saw_done !== 1'b0) $display("FAIL abort_done got %b want 0", saw_done); else passes++;
    checks++; if (128'(to32) !== prev) $display("FAIL abort_text_out got %h want %h", to32, prev); else passes++;
  endtask

  task automatic test_reset_mid;
    logic [127:0] res; int cyc;
    @(negedge clk); txt_bus = 128'h656b696c20646e75; mode = 1'b0; en[0] = 1'b1;
    @(posedge clk); #1; en[0] = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if ({kr, bz, dn} !== 9'b0) $display("FAIL midreset_flags got %b want 0", {kr, bz, dn}); else passes++;
    checks++; if ({to32, to16, to64} !== '0) $display("FAIL midreset_text got %h want 0", {to32, to16, to64}); else passes++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); en[0] = 1'b1;
    @(negedge clk); en[0] = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checks++; if ({dn[0], bz[0]} !== 2'b00) $display("FAIL midreset_needs_key got done/busy %b want 00", {dn[0], bz[0]}); else passes++;
    do_load(0, 128'h1b1a1918131211100b0a090803020100, cyc);
    do_block(0, 1'b0, 128'h656b696c20646e75, res, cyc);
    checks++; if (res !== 128'h44c8fc20b9dfa07a) $display("FAIL midreset_reload got %h want 44c8fc20b9dfa07a", res); else passes++;
  endtask

  initial begin
    test_reset();
    test_kat32();
    test_kat16();
    test_kat64();
    test_random();
    test_chain();
    test_back_to_back();
    test_ignored_en();
    test_load_en_same();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
